mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between an instruction
// fetch port and a data port. One access per cycle, fixed one-cycle latency,
// data has priority except when a waiting fetch has been passed over
// STARVE_MAX times in a row.
module mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_rdy,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RET_I,
        RET_D
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          grant_i;
    logic          grant_d;

    // Grant decision. A port is only ever in flight during its own RET state,
    // where a held req already counts as a new request, so pending == req.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (i_req && d_req) begin
                if (starve_cnt == STARVE_LIM) grant_i = 1'b1;
                else                          grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // RAM request mux and return-path outputs.
    always_comb begin
        ram_en    = grant_i | grant_d;
        ram_addr  = grant_i ? i_addr : d_addr;
        ram_wmask = grant_d ? d_wmask : '0;
        ram_wdata = d_wdata;
        i_rdy     = (state == RET_I) && !reset;
        d_rdy     = (state == RET_D) && !reset;
        i_rdata   = reset ? '0 : (i_rdy ? ram_rdata : i_rdata_q);
        d_rdata   = reset ? '0 : (d_rdy ? ram_rdata : d_rdata_q);
    end

    // State, starvation counter and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_i)      state <= RET_I;
            else if (grant_d) state <= RET_D;
            else              state <= IDLE;

            if (grant_i)
                starve_cnt <= '0;
            else if (grant_d && i_req && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;

            if (i_rdy) i_rdata_q <= ram_rdata;
            if (d_rdy) d_rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven directed test of mem_arbiter against a small
// behavioural RAM, plus a hand-written reset-during-fetch sequence and
// per-cycle invariant checks.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [13:0] i_addr;
    logic        i_rdy;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [13:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        d_rdy;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wmask;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    logic done = 1'b0;

    logic [31:0] mem [64];

    mem_arbiter #(.ADDR_W(14), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[5:0]];
            for (int unsigned b = 0; b < 4; b++)
                if (ram_wmask[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants sampled mid-cycle.
    always @(negedge clk) begin
        #3;
        if (!done) begin
            chk("rdy_exclusive", {31'd0, i_rdy & d_rdy}, 32'd0);
            if (ram_wmask != 4'd0)
                chk("wmask_needs_dgrant", {31'd0, ram_en & d_req & (ram_addr == d_addr)}, 32'd1);
            chk("cnt_bound", {31'd0, dut.starve_cnt <= 2'd2}, 32'd1);
        end
    end

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [13:0] iaddr;
        logic        dreq;
        logic [13:0] daddr;
        logic [3:0]  dwm;
        logic [31:0] dwd;
        logic        en;
        logic [13:0] addr;
        logic [3:0]  wm;
        logic        irdy;
        logic [31:0] irdata;
        logic        drdy;
        logic [31:0] drdata;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic ireq, input logic [13:0] iaddr,
        input logic dreq, input logic [13:0] daddr, input logic [3:0] dwm,
        input logic [31:0] dwd, input logic en, input logic [13:0] addr,
        input logic [3:0] wm, input logic irdy, input logic [31:0] irdata,
        input logic drdy, input logic [31:0] drdata, input logic [1:0] cnt);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq;
        v.daddr = daddr; v.dwm = dwm; v.dwd = dwd; v.en = en; v.addr = addr;
        v.wm = wm; v.irdy = irdy; v.irdata = irdata; v.drdy = drdy;
        v.drdata = drdata; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0;
        d_addr = '0; d_wmask = '0; d_wdata = '0; ram_rdata = '0;
        for (int unsigned a = 0; a < 64; a++) mem[a] = 32'h1000_0000 + a;
        mem[4]  = 32'h0000_0013;
        mem[16] = 32'h1122_3344;

        //               rst ireq iaddr dreq daddr  dwm     dwd           en addr   wm     irdy irdata        drdy drdata        cnt
        // reset: all quiet, a write presented during reset must not reach RAM
        vecs.push_back(mk(1, 1, 14'd4, 1, 14'h10, 4'b0000, 32'h0,         0, 14'd0,  4'b0000, 0, 32'h0,        0, 32'h0,        2'd0));
        vecs.push_back(mk(1, 0, 14'd0, 1, 14'h10, 4'b1111, 32'hDEADBEEF,  0, 14'd0,  4'b0000, 0, 32'h0,        0, 32'h0,        2'd0));
        // single fetch granted in first cycle after reset
        vecs.push_back(mk(0, 1, 14'd4, 0, 14'h0,  4'b0000, 32'h0,         1, 14'd4,  4'b0000, 0, 32'h0,        0, 32'h0,        2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'h0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 1, 32'h13,       0, 32'h0,        2'd0));
        // store byte 2 then back-to-back load of same word
        vecs.push_back(mk(0, 0, 14'd0, 1, 14'h10, 4'b0100, 32'h00AB0000,  1, 14'h10, 4'b0100, 0, 32'h13,       0, 32'h0,        2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 1, 14'h10, 4'b0000, 32'h0,         1, 14'h10, 4'b0000, 0, 32'h13,       1, 32'h11223344, 2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'h0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 0, 32'h13,       1, 32'h11AB3344, 2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'h0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 0, 32'h13,       0, 32'h11AB3344, 2'd0));
        // back-to-back fetch 0,1,2
        vecs.push_back(mk(0, 1, 14'd0, 0, 14'h0,  4'b0000, 32'h0,         1, 14'd0,  4'b0000, 0, 32'h13,       0, 32'h11AB3344, 2'd0));
        vecs.push_back(mk(0, 1, 14'd1, 0, 14'h0,  4'b0000, 32'h0,         1, 14'd1,  4'b0000, 1, 32'h10000000, 0, 32'h11AB3344, 2'd0));
        vecs.push_back(mk(0, 1, 14'd2, 0, 14'h0,  4'b0000, 32'h0,         1, 14'd2,  4'b0000, 1, 32'h10000001, 0, 32'h11AB3344, 2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'h0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 1, 32'h10000002, 0, 32'h11AB3344, 2'd0));
        // contention: D, D, I, D, D, I
        vecs.push_back(mk(0, 1, 14'd3, 1, 14'd5,  4'b0000, 32'h0,         1, 14'd5,  4'b0000, 0, 32'h10000002, 0, 32'h11AB3344, 2'd0));
        vecs.push_back(mk(0, 1, 14'd3, 1, 14'd5,  4'b0000, 32'h0,         1, 14'd5,  4'b0000, 0, 32'h10000002, 1, 32'h10000005, 2'd1));
        vecs.push_back(mk(0, 1, 14'd3, 1, 14'd5,  4'b0000, 32'h0,         1, 14'd3,  4'b0000, 0, 32'h10000002, 1, 32'h10000005, 2'd2));
        vecs.push_back(mk(0, 1, 14'd3, 1, 14'd5,  4'b0000, 32'h0,         1, 14'd5,  4'b0000, 1, 32'h10000003, 0, 32'h10000005, 2'd0));
        vecs.push_back(mk(0, 1, 14'd3, 1, 14'd5,  4'b0000, 32'h0,         1, 14'd5,  4'b0000, 0, 32'h10000003, 1, 32'h10000005, 2'd1));
        vecs.push_back(mk(0, 1, 14'd3, 1, 14'd5,  4'b0000, 32'h0,         1, 14'd3,  4'b0000, 0, 32'h10000003, 1, 32'h10000005, 2'd2));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'd0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 1, 32'h10000003, 0, 32'h10000005, 2'd0));
        // write granted, then reset in the return cycle
        vecs.push_back(mk(0, 0, 14'd0, 1, 14'd6,  4'b1111, 32'hCAFEF00D,  1, 14'd6,  4'b1111, 0, 32'h10000003, 0, 32'h10000005, 2'd0));
        vecs.push_back(mk(1, 0, 14'd0, 0, 14'd0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 0, 32'h0,        0, 32'h0,        2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'd0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 0, 32'h0,        0, 32'h0,        2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 1, 14'd6,  4'b0000, 32'h0,         1, 14'd6,  4'b0000, 0, 32'h0,        0, 32'h0,        2'd0));
        vecs.push_back(mk(0, 0, 14'd0, 0, 14'd0,  4'b0000, 32'h0,         0, 14'd0,  4'b0000, 0, 32'h0,        1, 32'hCAFEF00D, 2'd0));

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; i_req = vecs[i].ireq; i_addr = vecs[i].iaddr;
            d_req = vecs[i].dreq; d_addr = vecs[i].daddr;
            d_wmask = vecs[i].dwm; d_wdata = vecs[i].dwd;
            #1;
            chk($sformatf("v%0d_ram_en", i),    {31'd0, ram_en},       {31'd0, vecs[i].en});
            chk($sformatf("v%0d_ram_wmask", i), {28'd0, ram_wmask},    {28'd0, vecs[i].wm});
            if (vecs[i].en)
                chk($sformatf("v%0d_ram_addr", i), {18'd0, ram_addr},  {18'd0, vecs[i].addr});
            if (vecs[i].wm != 4'd0)
                chk($sformatf("v%0d_ram_wdata", i), ram_wdata,         vecs[i].dwd);
            chk($sformatf("v%0d_i_rdy", i),     {31'd0, i_rdy},        {31'd0, vecs[i].irdy});
            chk($sformatf("v%0d_i_rdata", i),   i_rdata,               vecs[i].irdata);
            chk($sformatf("v%0d_d_rdy", i),     {31'd0, d_rdy},        {31'd0, vecs[i].drdy});
            chk($sformatf("v%0d_d_rdata", i),   d_rdata,               vecs[i].drdata);
            chk($sformatf("v%0d_cnt", i),       {30'd0, dut.starve_cnt}, {30'd0, vecs[i].cnt});
        end

        // Reset while a fetch is returning with i_req still high.
        @(negedge clk);
        reset = 1'b0; i_req = 1'b1; i_addr = 14'd7; d_req = 1'b0; d_wmask = '0;
        #1;
        chk("seq_fetch_grant", {31'd0, ram_en}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("seq_rst_no_irdy", {31'd0, i_rdy}, 32'd0);
        chk("seq_rst_no_en", {31'd0, ram_en}, 32'd0);
        chk("seq_rst_irdata", i_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0; i_addr = 14'd8;
        #1;
        chk("seq_after_rst_no_irdy", {31'd0, i_rdy}, 32'd0);
        chk("seq_after_rst_grant", {31'd0, ram_en}, 32'd1);
        chk("seq_after_rst_addr", {18'd0, ram_addr}, 32'd8);
        chk("seq_after_rst_cnt", {30'd0, dut.starve_cnt}, 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        chk("seq_fetch8_rdy", {31'd0, i_rdy}, 32'd1);
        chk("seq_fetch8_data", i_rdata, 32'h1000_0008);
        chk("seq_fetch8_no_drdy", {31'd0, d_rdy}, 32'd0);

        @(negedge clk);
        done = 1'b1;
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
